// File: rtl/jk_excite_driver.sv
// jk_excite_driver: valid-ready write controller that excites a JK flip-flop bank, pulses it once per attempt and checks Q
// Build option JK_DRV_VERIFY_EN: when defined, settle wait, Q compare and retries are built; otherwise done follows the pulse.
// Ports:
//   clk, _reset          rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake; req_mode 00 load, 01 toggle, 1x hold
//   req_data             load target value or toggle mask
//   q_fb                 Q outputs of the flip-flop bank
//   j, k, jk_clk         per-bit excitation and single-cycle bank clock
//   busy, done, err      not idle / completion pulse / retries-exhausted pulse
module jk_excite_driver #(
    parameter int WIDTH     = 4,
    parameter int SETTLE    = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             _reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_mode,
    input  logic [WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             jk_clk,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [2:0] {S_IDLE, S_HOLDDN, S_SETUP, S_PULSE, S_SETTLE, S_CHECK, S_DONE} state_t;
    state_t state, state_n;
    logic rdy;
    logic accept, toggle, drive;
    logic [WIDTH-1:0] jq, kq;
    if (WIDTH < 1 || SETTLE < 0 || MAX_RETRY < 0) begin : g_bad_params
        $error("jk_excite_driver: illegal parameter values");
    end
    assign accept = req_valid & req_ready;
    assign toggle = req_mode == 2'b01;
`ifdef JK_DRV_VERIFY_EN
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
    logic [WIDTH-1:0] exp_q;
    logic [CW-1:0]    cnt;
    logic [RW-1:0]    retry;
    logic             match, can_retry;
    assign match     = q_fb == exp_q;
    assign can_retry = retry < RW'(MAX_RETRY);
`endif
    // rdy keeps req_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state <= S_IDLE;
            rdy   <= 1'b0;
            jq    <= '0;
            kq    <= '0;
`ifdef JK_DRV_VERIFY_EN
            exp_q <= '0;
            cnt   <= '0;
            retry <= '0;
`endif
        end else begin
            state <= state_n;
            rdy   <= 1'b1;
            if (accept) begin
                jq <= toggle ? req_data : ~q_fb & req_data;
                kq <= toggle ? req_data : q_fb & ~req_data;
            end
`ifdef JK_DRV_VERIFY_EN
            if (accept) begin
                exp_q <= req_mode == 2'b00 ? req_data : toggle ? q_fb ^ req_data : q_fb;
                retry <= '0;
            end
            cnt <= state == S_SETTLE ? cnt + 1'b1 : '0;
            // retries always steer toward the captured target, even after a toggle
            if (state == S_CHECK && !match && can_retry) begin
                retry <= retry + 1'b1;
                jq    <= ~q_fb & exp_q;
                kq    <= q_fb & ~exp_q;
            end
`endif
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   state_n = accept ? (req_mode[1] ? S_HOLDDN : S_SETUP) : S_IDLE;
            S_SETUP:  state_n = S_PULSE;
`ifdef JK_DRV_VERIFY_EN
            S_PULSE:  state_n = SETTLE == 0 ? S_CHECK : S_SETTLE;
            S_SETTLE: state_n = cnt == CW'(SETTLE - 1) ? S_CHECK : S_SETTLE;
            S_CHECK:  state_n = !match && can_retry ? S_SETUP : S_IDLE;
`else
            S_PULSE:  state_n = S_DONE;
`endif
            default:  state_n = S_IDLE;
        endcase
    end
    assign drive     = state == S_SETUP || state == S_PULSE;
    assign j         = drive ? jq : '0;
    assign k         = drive ? kq : '0;
    assign jk_clk    = state == S_PULSE;
    assign busy      = state != S_IDLE;
    assign req_ready = rdy && state == S_IDLE;
`ifdef JK_DRV_VERIFY_EN
    assign done = state == S_HOLDDN || (state == S_CHECK && match);
    assign err  = state == S_CHECK && !match && !can_retry;
`else
    assign done = state == S_HOLDDN || state == S_DONE;
    assign err  = 1'b0;
`endif
endmodule

// File: tb/tb_jk_excite_driver.sv
// tb_jk_excite_driver: scoreboard bench driving jk_excite_driver into a modelled four-bit JK flip-flop bank
module tb_jk_excite_driver;
    localparam int W  = 4;
    localparam int ST = 2;
    localparam int MR = 3;
`ifdef JK_DRV_VERIFY_EN
    localparam logic VER = 1'b1;
`else
    localparam logic VER = 1'b0;
`endif
    localparam int LAT = VER ? 3 + ST : 3;

    logic         clk = 1'b0;
    logic         _reset = 1'b0;
    logic         req_valid = 1'b0;
    logic [1:0]   req_mode = 2'b00;
    logic [W-1:0] req_data = '0;
    logic [W-1:0] q_fb, j, k;
    logic         req_ready, jk_clk, busy, done, err;

    always #5 clk = ~clk;

    jk_excite_driver #(.WIDTH(W), .SETTLE(ST), .MAX_RETRY(MR)) dut (
        .clk(clk), ._reset(_reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_data(req_data), .q_fb(q_fb), .j(j), .k(k),
        .jk_clk(jk_clk), .busy(busy), .done(done), .err(err)
    );

    // JK bank: Q+ = J&~Q | ~K&Q on each bank clock; stuck / skip_until model a failing bank
    logic [W-1:0] q = '0;
    logic         stuck = 1'b0;
    int           pulses = 0;
    int           skip_until = 0;
    always @(posedge jk_clk) begin
        if (!stuck && pulses >= skip_until) q <= (j & ~q) | (~k & q);
        pulses <= pulses + 1;
    end
    assign q_fb = q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    typedef struct {
        logic         is_err;
        int           lat;
        int           np;
        logic [W-1:0] q;
        int           c0;
        int           p0;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        exp_t e;
        if (done || err) begin
            chk("done_err_exclusive", {31'b0, done & err}, 0);
            if (sb.size() == 0) chk("unexpected_completion", {31'b0, done | err}, 0);
            else begin
                e = sb.pop_front();
                chk("err_flag", {31'b0, err}, {31'b0, e.is_err});
                chk("done_flag", {31'b0, done}, {31'b0, !e.is_err});
                chk("latency", cyc - e.c0 + 1, e.lat);
                chk("pulse_count", pulses - e.p0, e.np);
                chk("bank_q", {28'b0, q}, {28'b0, e.q});
            end
        end
    end

    task automatic issue(input logic [1:0] m, input logic [W-1:0] d, input logic is_err,
                         input int lat, input int np, input logic [W-1:0] qe);
        @(negedge clk);
        chk("ready_before_accept", {31'b0, req_ready}, 1);
        req_valid = 1'b1;
        req_mode  = m;
        req_data  = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        sb.push_back(exp_t'{is_err, lat, np, qe, cyc, pulses});
        chk("busy_after_accept", {31'b0, busy}, 1);
    endtask

    task automatic finish_req();
        int t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", {31'b0, busy}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset held: request offered, nothing may respond
        repeat (2) @(negedge clk);
        req_valid = 1'b1;
        req_data  = 4'hf;
        @(negedge clk);
        chk("reset_outputs", {19'b0, req_ready, busy, done, err, jk_clk, j, k}, 0);
        @(negedge clk);
        chk("reset_outputs_2", {19'b0, req_ready, busy, done, err, jk_clk, j, k}, 0);
        req_valid = 1'b0;
        _reset = 1'b1;
        #1 chk("ready_before_first_edge", {31'b0, req_ready}, 0);
        @(posedge clk);
        #1 chk("ready_after_release", {31'b0, req_ready}, 1);
        chk("no_pulse_in_reset", pulses, 0);

        // load 1010 from 0000; a hold offered while busy must be ignored
        issue(2'b00, 4'b1010, 1'b0, LAT, 1, 4'b1010);
        chk("load_setup_j", {28'b0, j}, 32'b1010);
        chk("load_setup_k", {28'b0, k}, 0);
        chk("load_setup_clk", {31'b0, jk_clk}, 0);
        req_valid = 1'b1;
        req_mode  = 2'b10;
        repeat (2) @(negedge clk);
        chk("ready_low_while_busy", {31'b0, req_ready}, 0);
        req_valid = 1'b0;
        finish_req();

        // load 1100 then toggle 0110 -> 1010
        issue(2'b00, 4'b1100, 1'b0, LAT, 1, 4'b1100);
        finish_req();
        issue(2'b01, 4'b0110, 1'b0, LAT, 1, 4'b1010);
        chk("toggle_setup_j", {28'b0, j}, 32'b0110);
        chk("toggle_setup_k", {28'b0, k}, 32'b0110);
        finish_req();

        // load equal to current Q still pulses with J=K=0
        issue(2'b00, 4'b1010, 1'b0, LAT, 1, 4'b1010);
        chk("same_value_j", {28'b0, j}, 0);
        chk("same_value_k", {28'b0, k}, 0);
        finish_req();

        // stuck bank at 0000, load 0001
        issue(2'b00, 4'b0000, 1'b0, LAT, 1, 4'b0000);
        finish_req();
        stuck = 1'b1;
        issue(2'b00, 4'b0001, VER, VER ? (MR + 1) * LAT : LAT, VER ? MR + 1 : 1, 4'b0000);
        finish_req();
        @(negedge clk);
        chk("ready_after_stuck", {31'b0, req_ready}, 1);
        stuck = 1'b0;

        // first pulse lost, load 0011
        skip_until = pulses + 1;
        issue(2'b00, 4'b0011, 1'b0, VER ? 2 * LAT : LAT, VER ? 2 : 1, VER ? 4'b0011 : 4'b0000);
`ifdef JK_DRV_VERIFY_EN
        repeat (6) @(negedge clk);
        chk("retry_setup_j", {28'b0, j}, 32'b0011);
        chk("retry_setup_k", {28'b0, k}, 0);
        chk("retry_setup_clk", {31'b0, jk_clk}, 0);
`endif
        finish_req();

        // reset asserted during PULSE aborts immediately
        @(negedge clk);
        req_valid = 1'b1;
        req_mode  = 2'b00;
        req_data  = 4'b1111;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 chk("pulse_reached", {31'b0, jk_clk}, 1);
        _reset = 1'b0;
        #1 chk("async_abort", {19'b0, req_ready, busy, done, err, jk_clk, j, k}, 0);
        repeat (3) @(negedge clk);
        _reset = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_abort", {31'b0, req_ready}, 1);

        // hold and reserved mode complete next cycle with no pulse
        issue(2'b10, 4'b0101, 1'b0, 1, 0, q);
        finish_req();
        issue(2'b11, 4'b1001, 1'b0, 1, 0, q);
        finish_req();

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
